// File: rtl/result_buffer_if.sv
// Result-buffer bus: pipeline result strobe on the write side, valid/ready head entry on the read side.
// The master modport belongs to whoever drives the pipeline results and consumes the converted head.
interface result_buffer_if #(
    parameter int ITERATION_WORD_WIDTH = 32,
    parameter int OUTPUT_WIDTH         = 16,
    parameter int FIFO_DEPTH           = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                            in_valid;
    logic [ITERATION_WORD_WIDTH-1:0] in_x;
    logic [ITERATION_WORD_WIDTH-1:0] in_y;
    logic [ITERATION_WORD_WIDTH-1:0] in_z;

    logic                    out_valid;
    logic                    out_ready;
    logic [OUTPUT_WIDTH-1:0] out_x;
    logic [OUTPUT_WIDTH-1:0] out_y;
    logic [OUTPUT_WIDTH-1:0] out_z;
    logic                    out_sat;
    logic [CNT_W-1:0]        count;
    logic                    overflow;

    modport master (
        output in_valid, in_x, in_y, in_z, out_ready,
        input  out_valid, out_x, out_y, out_z, out_sat, count, overflow
    );

    modport slave (
        input  in_valid, in_x, in_y, in_z, out_ready,
        output out_valid, out_x, out_y, out_z, out_sat, count, overflow
    );
endinterface

// File: rtl/result_buffer.sv
// Converts Q12.20 pipeline results to saturated Q7.8 and queues them in a small FIFO.
// Define RESULT_BUFFER_ROUND_EN for round-half-up conversion; default build truncates.
module result_buffer #(
    parameter int ITERATION_WORD_WIDTH      = 32,
    parameter int ITERATION_WORD_FRAC_WIDTH = 20,
    parameter int OUTPUT_WIDTH              = 16,
    parameter int OUTPUT_FRAC_WIDTH         = 8,
    parameter int FIFO_DEPTH                = 4
) (
    input logic            clk,
    input logic            rst,
    result_buffer_if.slave io_bus
);
    localparam int IW    = ITERATION_WORD_WIDTH;
    localparam int OW    = OUTPUT_WIDTH;
    localparam int EXT_W = IW + 1;
    localparam int SHIFT = ITERATION_WORD_FRAC_WIDTH - OUTPUT_FRAC_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 3 * OW + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic signed [EXT_W-1:0] OUT_MAX =
        $signed({{(EXT_W - OW + 1){1'b0}}, {(OW - 1){1'b1}}});
    localparam logic signed [EXT_W-1:0] OUT_MIN =
        $signed({{(EXT_W - OW + 1){1'b1}}, {(OW - 1){1'b0}}});
`ifdef RESULT_BUFFER_ROUND_EN
    localparam logic signed [EXT_W-1:0] ROUND_HALF = EXT_W'(1) <<< (SHIFT - 1);
`endif

    // Returns {sat, value}; one extra bit of headroom so rounding can never wrap.
    function automatic logic [OW:0] f_convert(input logic [IW-1:0] i_word);
        logic signed [EXT_W-1:0] v_ext;
        logic signed [EXT_W-1:0] v_shift;
        v_ext = $signed({i_word[IW-1], i_word});
`ifdef RESULT_BUFFER_ROUND_EN
        v_ext = v_ext + ROUND_HALF;
`endif
        v_shift = v_ext >>> SHIFT;
        if (v_shift > OUT_MAX) begin
            return {1'b1, 1'b0, {(OW - 1){1'b1}}};
        end else if (v_shift < OUT_MIN) begin
            return {1'b1, 1'b1, {(OW - 1){1'b0}}};
        end else begin
            return {1'b0, v_shift[OW-1:0]};
        end
    endfunction

    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic [OW:0]      w_cx;
    logic [OW:0]      w_cy;
    logic [OW:0]      w_cz;
    logic [ENT_W-1:0] w_entry;
    logic [ENT_W-1:0] w_head;
    logic             w_not_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    always_comb begin
        w_cx    = f_convert(io_bus.in_x);
        w_cy    = f_convert(io_bus.in_y);
        w_cz    = f_convert(io_bus.in_z);
        w_entry = {w_cx[OW] | w_cy[OW] | w_cz[OW], w_cx[OW-1:0], w_cy[OW-1:0], w_cz[OW-1:0]};
    end

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == FULL_COUNT);
    assign w_pop       = !rst && w_not_empty && io_bus.out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push      = !rst && io_bus.in_valid && (!w_full || w_pop);
    assign w_drop      = !rst && io_bus.in_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Gating the head with occupancy keeps the outputs at zero after reset.
    assign w_head = w_not_empty ? r_mem[r_rd_ptr] : '0;

    assign io_bus.out_valid = w_not_empty;
    assign io_bus.out_sat   = w_head[ENT_W-1];
    assign io_bus.out_x     = w_head[3*OW-1:2*OW];
    assign io_bus.out_y     = w_head[2*OW-1:OW];
    assign io_bus.out_z     = w_head[OW-1:0];
    assign io_bus.count     = r_count;
    assign io_bus.overflow  = r_overflow;
endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter ITERATION_WORD_WIDTH, default 32, input word width.
REQ-002 SHALL have parameter ITERATION_WORD_FRAC_WIDTH, default 20, input fraction bits (Q12.20).
REQ-003 SHALL have parameter OUTPUT_WIDTH, default 16, output word width.
REQ-004 SHALL have parameter OUTPUT_FRAC_WIDTH, default 8, output fraction bits (Q7.8, signed).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, entries; power of two, at least 2.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1, pipeline result strobe; no backpressure toward the pipeline.
REQ-009 SHALL have ports in_x, in_y, in_z, input, ITERATION_WORD_WIDTH each, signed pipeline results.
REQ-010 SHALL have port out_valid, output, 1, head entry available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts head.
REQ-012 SHALL have ports out_x, out_y, out_z, output, OUTPUT_WIDTH each, converted head entry.
REQ-013 SHALL have port out_sat, output, 1, head entry had at least one saturated field.
REQ-014 SHALL have port count, output, clog2(FIFO_DEPTH)+1, current occupancy.
REQ-015 SHALL have port overflow, output, 1, sticky drop indicator.

Function
REQ-016 Conversion SHALL be combinational before the FIFO write: shift right arithmetically by (ITERATION_WORD_FRAC_WIDTH-OUTPUT_FRAC_WIDTH)=12 bits, computed at ITERATION_WORD_WIDTH+1 bits so no intermediate wrap.
REQ-017 Conversion SHALL saturate: results above 0x7FFF give 0x7FFF, below 0x8000 (as signed) give 0x8000; the entry's sat bit is the OR over x, y, z.
REQ-018 Push SHALL occur when in_valid=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle).
REQ-019 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 Latency SHALL be 1 cycle: in_valid at edge N into empty FIFO gives out_valid=1 with that data after edge N+1.
REQ-021 Ordering SHALL be strict FIFO; read/write pointers wrap modulo FIFO_DEPTH.
REQ-022 Full plus in_valid plus no pop SHALL drop the input, leave contents and count unchanged, and set overflow=1 until reset.
REQ-023 Full plus simultaneous push and pop SHALL accept both; count stays FIFO_DEPTH; overflow unchanged.
REQ-024 Empty plus in_valid SHALL push only; no same-cycle bypass to the outputs.
REQ-025 out_valid SHALL equal (count!=0); out_x/y/z/out_sat SHALL be the head entry and stay stable while out_valid=1 and out_ready=0.

Reset
REQ-026 rst=1 at an edge SHALL set pointers=0, count=0, out_valid=0, overflow=0, and out_x/y/z=0, out_sat=0; stored entries are discarded.
REQ-027 in_valid SHALL be ignored in any cycle where rst=1, including mid-operation.

Configuration
REQ-028 Macro RESULT_BUFFER_ROUND_EN defined: add 1<<11 (half output LSB) before the shift (round-half-up), then saturate.
REQ-029 Macro RESULT_BUFFER_ROUND_EN undefined: truncate (plain arithmetic shift), then saturate; all other behaviour identical.

Verification
REQ-030 in_x=0x0010_0000 (1.0), in_valid one cycle -> next cycle out_valid=1, out_x=0x0100, out_sat=0.
REQ-031 in_x=0x0010_0800 -> out_x=0x0101 with RESULT_BUFFER_ROUND_EN, 0x0100 without.
REQ-032 in_y=0x0800_0000 (+128.0) -> out_y=0x7FFF, out_sat=1; in_y=0xF7F0_0000 (-129.0) -> out_y=0x8000, out_sat=1.
REQ-033 out_ready=0, 5 consecutive pushes (tags 1..5) -> count=4, overflow=1; then out_ready=1 -> tags 1..4 in order, tag 5 never appears.
REQ-034 FIFO full, in_valid=1 and out_ready=1 same cycle -> count stays 4, overflow stays 0, new entry emerges last.
REQ-035 count=3, rst pulsed one cycle with in_valid=1 -> after edge out_valid=0, count=0, overflow=0; the in_valid during reset is not stored.
